// File: rtl/panel_pkg.sv
// Shared constants and types for the LED panel capture path.
package panel_pkg;

    localparam int unsigned PANEL_DISPLAY_WIDTH = 416;
    localparam int unsigned PANEL_ADDR_WIDTH    = 3;
    localparam int unsigned PANEL_PLANES        = 8;
    localparam int unsigned PLANE_W             = $clog2(PANEL_PLANES);

    typedef logic [PLANE_W-1:0] plane_t;

    localparam plane_t PLANE_MAX = plane_t'(PANEL_PLANES - 1);

    // Drain FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage

// File: rtl/panel_line_buffer.sv
// Ping-pong pair of one-bit-wide line stores with per-buffer full flag and row/plane tags.
module panel_line_buffer
    import panel_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH   = PANEL_DISPLAY_WIDTH,
    parameter int unsigned DISP_ADDR_WIDTH = PANEL_ADDR_WIDTH,
    localparam int unsigned IDX_W          = $clog2(DISPLAY_WIDTH)
) (
    input  logic                       clk_48mhz,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic                       wr_data,
    input  logic                       commit,
    input  logic [DISP_ADDR_WIDTH-1:0] commit_row,
    input  logic [2:0]                 commit_plane,
    input  logic                       release_en,
    input  logic                       release_sel,
    input  logic                       rd_en,
    input  logic                       rd_sel,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic                       rd_data,
    input  logic                       tag_sel,
    output logic [DISP_ADDR_WIDTH-1:0] tag_row_c,
    output logic [2:0]                 tag_plane_c,
    output logic [1:0]                 full
);

    logic                       mem [2][DISPLAY_WIDTH];
    logic [DISP_ADDR_WIDTH-1:0] row_tag [2];
    logic [2:0]                 plane_tag [2];

    always_ff @(posedge clk_48mhz) begin
        if (wr_en) mem[wr_sel][wr_idx] <= wr_data;
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset)      rd_data <= 1'b0;
        else if (rd_en) rd_data <= mem[rd_sel][rd_idx];
    end

    // A commit to the buffer being released in the same cycle wins
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            full <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                row_tag[i]   <= '0;
                plane_tag[i] <= '0;
            end
        end else begin
            if (release_en) full[release_sel] <= 1'b0;
            if (commit) begin
                full[wr_sel]      <= 1'b1;
                row_tag[wr_sel]   <= commit_row;
                plane_tag[wr_sel] <= commit_plane;
            end
        end
    end

    assign tag_row_c   = row_tag[tag_sel];
    assign tag_plane_c = plane_tag[tag_sel];

endmodule

// File: rtl/panel_capture.sv
// Receive side of the shift-register LED panel bus: captures scan lines and
// replays them as per-pixel framebuffer writes.
module panel_capture
    import panel_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH   = PANEL_DISPLAY_WIDTH,
    parameter int unsigned DISP_ADDR_WIDTH = PANEL_ADDR_WIDTH,
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                       clk_48mhz,
    input  logic                       reset,
    input  logic                       panel_clk,
    input  logic                       panel_data,
    input  logic                       panel_latch,
    input  logic                       panel_en,
    input  logic [DISP_ADDR_WIDTH-1:0] panel_addr,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic                       wr_bit,
    output logic [2:0]                 wr_plane,
    output logic                       frame_done,
    output logic                       panel_en_sync,
    output logic                       length_err,
    output logic                       overrun
);

    localparam int unsigned IDX_W = $clog2(DISPLAY_WIDTH);
    localparam int unsigned CNT_W = $clog2(DISPLAY_WIDTH + 2);

    logic [SYNC_STAGES-1:0]     clk_sh, data_sh, latch_sh, en_sh;
    logic [DISP_ADDR_WIDTH-1:0] addr_sh [SYNC_STAGES];
    logic                       clk_prev, latch_prev;

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            clk_sh     <= '0;
            data_sh    <= '0;
            latch_sh   <= '0;
            en_sh      <= '1;
            clk_prev   <= 1'b0;
            latch_prev <= 1'b0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) addr_sh[i] <= '0;
        end else begin
            clk_sh     <= {clk_sh[SYNC_STAGES-2:0], panel_clk};
            data_sh    <= {data_sh[SYNC_STAGES-2:0], panel_data};
            latch_sh   <= {latch_sh[SYNC_STAGES-2:0], panel_latch};
            en_sh      <= {en_sh[SYNC_STAGES-2:0], panel_en};
            clk_prev   <= clk_sh[SYNC_STAGES-1];
            latch_prev <= latch_sh[SYNC_STAGES-1];
            addr_sh[0] <= panel_addr;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) addr_sh[i] <= addr_sh[i-1];
        end
    end

    logic                       clk_s, data_s, latch_s;
    logic [DISP_ADDR_WIDTH-1:0] addr_s;
    assign clk_s         = clk_sh[SYNC_STAGES-1];
    assign data_s        = data_sh[SYNC_STAGES-1];
    assign latch_s       = latch_sh[SYNC_STAGES-1];
    assign addr_s        = addr_sh[SYNC_STAGES-1];
    assign panel_en_sync = en_sh[SYNC_STAGES-1];

    logic                       clk_rise_c, latch_rise_c, shift_c, in_range_c, len_ok_c;
    logic                       fill_free_c, commit_c, buf_wr_c, release_c;
    logic [CNT_W-1:0]           bit_cnt;
    logic                       fill_sel, drain_sel, line_dropped;
    logic [DISP_ADDR_WIDTH-1:0] prev_row;
    plane_t                     plane, plane_next_c;
    logic [1:0]                 full;

    assign clk_rise_c   = clk_s & ~clk_prev;
    assign latch_rise_c = latch_s & ~latch_prev;
    assign shift_c      = clk_rise_c & ~latch_s;
    assign in_range_c   = bit_cnt < CNT_W'(DISPLAY_WIDTH);
    assign len_ok_c     = bit_cnt == CNT_W'(DISPLAY_WIDTH);
    assign buf_wr_c     = shift_c & in_range_c & ~full[fill_sel];
    assign fill_free_c  = ~full[fill_sel] | (release_c & (drain_sel == fill_sel));
    assign commit_c     = latch_rise_c & len_ok_c & ~line_dropped & fill_free_c;
    assign plane_next_c = (addr_s != prev_row) ? '0 :
                          (plane == PLANE_MAX) ? plane : plane + plane_t'(1);

    // Bit count saturates one past the line width so long lines stay detectable
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            bit_cnt      <= '0;
            fill_sel     <= 1'b0;
            line_dropped <= 1'b0;
            prev_row     <= '0;
            plane        <= '0;
            frame_done   <= 1'b0;
            length_err   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (shift_c && bit_cnt != CNT_W'(DISPLAY_WIDTH + 1)) bit_cnt <= bit_cnt + CNT_W'(1);
            if (shift_c && in_range_c && full[fill_sel]) line_dropped <= 1'b1;
            if (latch_rise_c) begin
                bit_cnt      <= '0;
                line_dropped <= 1'b0;
                prev_row     <= addr_s;
                plane        <= plane_next_c;
                frame_done   <= (prev_row != '0) && (addr_s == '0);
                if (!len_ok_c)     length_err <= 1'b1;
                else if (!commit_c) overrun   <= 1'b1;
                if (commit_c) fill_sel <= ~fill_sel;
            end
        end
    end

    logic [0:0]                 state, state_nx;
    logic                       drain_sel_nx, valid_nx, rd_en_c, rd_sel_c, tag_sel_c;
    logic [IDX_W-1:0]           rd_idx, rd_idx_nx;
    logic [ADDR_WIDTH-1:0]      addr_nx, row_base_c;
    logic [2:0]                 plane_nx, tag_plane_c;
    logic [DISP_ADDR_WIDTH-1:0] tag_row_c;

    // In DRAIN the only tag needed is the pending buffer's, for back-to-back chaining
    assign tag_sel_c  = (state == ST_DRAIN) ? ~drain_sel : drain_sel;
    assign row_base_c = ADDR_WIDTH'(tag_row_c) * ADDR_WIDTH'(DISPLAY_WIDTH);

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state     <= ST_IDLE;
            drain_sel <= 1'b0;
            rd_idx    <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_plane  <= '0;
        end else begin
            state     <= state_nx;
            drain_sel <= drain_sel_nx;
            rd_idx    <= rd_idx_nx;
            wr_valid  <= valid_nx;
            wr_addr   <= addr_nx;
            wr_plane  <= plane_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        drain_sel_nx = drain_sel;
        rd_idx_nx    = rd_idx;
        valid_nx     = wr_valid;
        addr_nx      = wr_addr;
        plane_nx     = wr_plane;
        rd_en_c      = 1'b0;
        rd_sel_c     = drain_sel;
        release_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (full[drain_sel]) begin
                    rd_en_c   = 1'b1;
                    rd_idx_nx = '0;
                    valid_nx  = 1'b1;
                    addr_nx   = row_base_c;
                    plane_nx  = tag_plane_c;
                    state_nx  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr_valid && wr_ready) begin
                    if (rd_idx == IDX_W'(DISPLAY_WIDTH - 1)) begin
                        release_c    = 1'b1;
                        drain_sel_nx = ~drain_sel;
                        if (full[~drain_sel]) begin
                            rd_en_c   = 1'b1;
                            rd_sel_c  = ~drain_sel;
                            rd_idx_nx = '0;
                            addr_nx   = row_base_c;
                            plane_nx  = tag_plane_c;
                        end else begin
                            valid_nx = 1'b0;
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        rd_en_c   = 1'b1;
                        rd_idx_nx = rd_idx + IDX_W'(1);
                        addr_nx   = wr_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    panel_line_buffer #(
        .DISPLAY_WIDTH   (DISPLAY_WIDTH),
        .DISP_ADDR_WIDTH (DISP_ADDR_WIDTH)
    ) u_line_buffer (
        .clk_48mhz    (clk_48mhz),
        .reset        (reset),
        .wr_en        (buf_wr_c),
        .wr_sel       (fill_sel),
        .wr_idx       (IDX_W'(bit_cnt)),
        .wr_data      (data_s),
        .commit       (commit_c),
        .commit_row   (addr_s),
        .commit_plane (plane_next_c),
        .release_en   (release_c),
        .release_sel  (drain_sel),
        .rd_en        (rd_en_c),
        .rd_sel       (rd_sel_c),
        .rd_idx       (rd_idx_nx),
        .rd_data      (wr_bit),
        .tag_sel      (tag_sel_c),
        .tag_row_c    (tag_row_c),
        .tag_plane_c  (tag_plane_c),
        .full         (full)
    );

endmodule

// File: tb/tb_panel_capture.sv
// Directed/randomized bench for panel_capture with a line-level reference model.
module tb_panel_capture;

    localparam int W = 416;

    logic        clk_48mhz = 1'b0;
    logic        reset = 1'b1;
    logic        panel_clk = 1'b0, panel_data = 1'b0, panel_latch = 1'b0, panel_en = 1'b1;
    logic [2:0]  panel_addr = '0;
    logic        wr_ready = 1'b0;
    logic        wr_valid, wr_bit, frame_done, panel_en_sync, length_err, overrun;
    logic [11:0] wr_addr;
    logic [2:0]  wr_plane;

    panel_capture dut (
        .clk_48mhz     (clk_48mhz),
        .reset         (reset),
        .panel_clk     (panel_clk),
        .panel_data    (panel_data),
        .panel_latch   (panel_latch),
        .panel_en      (panel_en),
        .panel_addr    (panel_addr),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_bit        (wr_bit),
        .wr_plane      (wr_plane),
        .frame_done    (frame_done),
        .panel_en_sync (panel_en_sync),
        .length_err    (length_err),
        .overrun       (overrun)
    );

    initial forever #10 clk_48mhz = ~clk_48mhz;

    typedef struct {
        logic [11:0] addr;
        logic        pix;
        logic [2:0]  plane;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    bit   line_bits [W];
    int   n_checks = 0, n_errors = 0;
    int   ready_mode = 1;
    int   lines_done = 0, retained = 0, writes_seen = 0, frames_seen = 0, exp_frames = 0;
    int   m_prev = 0, m_plane = 0;
    logic exp_len = 1'b0, exp_ovr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: update ready after the edge, then check the write port at the falling edge
    task automatic tick();
        exp_t e;
        @(posedge clk_48mhz);
        #1;
        case (ready_mode)
            0:       wr_ready = 1'b0;
            1:       wr_ready = 1'b1;
            default: wr_ready = ($urandom_range(3) != 0);
        endcase
        @(negedge clk_48mhz);
        if (wr_valid === 1'b1 && !reset) begin
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_bit", 32'(wr_bit), 32'(e.pix));
                chk("wr_plane", 32'(wr_plane), 32'(e.plane));
                if (wr_ready) begin
                    e = exp_q.pop_front();
                    writes_seen++;
                    if (e.last) lines_done++;
                end
            end
        end
        if (frame_done === 1'b1) frames_seen++;
    endtask

    task automatic model_latch(input int row, input int nbits);
        exp_t e;
        if (row != m_prev) m_plane = 0;
        else if (m_plane < 7) m_plane++;
        if (m_prev != 0 && row == 0) exp_frames++;
        m_prev = row;
        if (nbits != W) exp_len = 1'b1;
        else if (retained - lines_done >= 2) exp_ovr = 1'b1;
        else begin
            retained++;
            for (int i = 0; i < W; i++) begin
                e.addr  = 12'(row * W + i);
                e.pix   = line_bits[i];
                e.plane = 3'(m_plane);
                e.last  = (i == W - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_line(input int row, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            panel_data = (i < W) ? line_bits[i] : 1'($urandom_range(1));
            panel_clk  = 1'b0;
            tick(); tick();
            panel_clk = 1'b1;
            tick(); tick();
        end
        panel_clk  = 1'b0;
        panel_data = 1'b0;
        panel_addr = 3'(row);
        tick(); tick();
        panel_latch = 1'b1;
        panel_clk   = 1'b1;
        model_latch(row, nbits);
        repeat (3) tick();
        panel_latch = 1'b0;
        panel_clk   = 1'b0;
        repeat (3) tick();
    endtask

    task automatic fill_random();
        for (int i = 0; i < W; i++) line_bits[i] = 1'($urandom_range(1));
    endtask

    task automatic wait_drain(input string tag);
        int budget = 6000;
        repeat (8) tick();
        while ((exp_q.size() != 0 || wr_valid === 1'b1) && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        repeat (4) tick();
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_length_err"}, 32'(length_err), 32'(exp_len));
        chk({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
        chk({tag, "_frames"}, 32'(frames_seen), 32'(exp_frames));
    endtask

    initial begin
        logic [7:0] pat;
        int         ws;
        int         budget;

        // Reset values, with panel_en driven low to show the sync chain resets high
        panel_en = 1'b0;
        reset    = 1'b1;
        repeat (4) tick();
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_bit", 32'(wr_bit), 32'd0);
        chk("rst_wr_plane", 32'(wr_plane), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_length_err", 32'(length_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_panel_en_sync", 32'(panel_en_sync), 32'd1);
        reset = 1'b0;
        repeat (4) tick();
        chk("en_sync_low", 32'(panel_en_sync), 32'd0);
        panel_en = 1'b1;
        repeat (4) tick();
        chk("en_sync_high", 32'(panel_en_sync), 32'd1);

        // Rows 0..7 then back to 0: a single frame_done on the wrap
        ready_mode = 2;
        for (int r = 0; r < 8; r++) begin
            fill_random();
            send_line(r, W);
            wait_drain("frame_rows");
        end
        check_flags("frame_pre_wrap");
        fill_random();
        send_line(0, W);
        wait_drain("frame_wrap");
        check_flags("frame_post_wrap");

        // 0xA5 pattern, MSB first, row 3
        ready_mode = 1;
        pat = 8'hA5;
        for (int i = 0; i < W; i++) line_bits[i] = pat[7 - (i % 8)];
        send_line(3, W);
        wait_drain("a5_line");
        check_flags("a5_line");

        // Eight lines on row 5 walk the planes, then row 6 restarts at plane 0
        ready_mode = 2;
        for (int k = 0; k < 9; k++) begin
            fill_random();
            send_line((k < 8) ? 5 : 6, W);
            wait_drain("planes");
        end
        check_flags("planes");

        // Short line is flagged and dropped, next full line drains
        fill_random();
        send_line(4, W - 1);
        wait_drain("short_line");
        check_flags("short_line");
        fill_random();
        send_line(4, W);
        wait_drain("after_short");
        check_flags("after_short");

        // Stalled consumer: two lines buffered, third overruns
        ready_mode = 0;
        ws = writes_seen;
        for (int k = 0; k < 3; k++) begin
            fill_random();
            send_line(1, W);
        end
        repeat (8) tick();
        check_flags("stall_overrun");
        ready_mode = 1;
        wait_drain("stall_release");
        chk("stall_write_count", 32'(writes_seen - ws), 32'(2 * W));

        // Reset in the middle of a drain
        ws = writes_seen;
        fill_random();
        send_line(2, W);
        budget = 2000;
        while (writes_seen - ws < 100 && budget > 0) begin
            tick();
            budget--;
        end
        chk("mid_drain_reached", 32'(writes_seen - ws >= 100), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("mid_rst_length_err", 32'(length_err), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        exp_q.delete();
        retained = lines_done;
        m_prev   = 0;
        m_plane  = 0;
        exp_len  = 1'b0;
        exp_ovr  = 1'b0;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        ws = writes_seen;
        fill_random();
        send_line(6, W);
        wait_drain("post_reset");
        chk("post_reset_write_count", 32'(writes_seen - ws), 32'(W));
        check_flags("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
